// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle 16-bit word data memory at the far end of EX/MEM.
// It accepts one load or store, holds the pipeline while the access is
// pending, commits after LATENCY busy cycles, then strobes data_valid for one
// cycle.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous reset, active-low
//   MemWrite   in   store request
//   MemRead    in   load request
//   addr[15:0] in   byte address; word index = addr[MEM_AW:1]
//   wdata[15:0]in   store data
//   stall      out  hold request: (IDLE & req) | BUSY, combinational
//   data_valid out  one-cycle completion strobe (DONE state)
//   rdata[15:0]out  last committed load result
//   busy_err   out  sticky: read and write requested together at accept
module dmem_responder #(
  parameter int unsigned MEM_AW  = 10,
  parameter int unsigned LATENCY = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  output logic        stall,
  output logic        data_valid,
  output logic [15:0] rdata,
  output logic        busy_err
);

  localparam int unsigned DW    = 16;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 2 ** MEM_AW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic [MEM_AW-1:0]  r_idx;
  logic [DW-1:0]      r_wdata;
  logic               r_op_wr;
  logic [DW-1:0]      r_rdata;
  logic               r_busy_err;
  logic [DW-1:0]      r_mem [DEPTH];

  logic               w_req;
  logic               w_accept;
  logic               w_commit;
  logic [MEM_AW-1:0]  w_idx;
  logic               w_unused_addr;

  assign w_req = MemRead | MemWrite;
  assign w_idx = addr[MEM_AW:1];

  // Byte-lane bit and bits above the array are intentionally dropped (wrap).
  assign w_unused_addr = ^{addr[DW-1:MEM_AW+1], addr[0]};

  // Next-state, counter and strobe decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_commit    = 1'b0;
    stall       = 1'b0;
    data_valid  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req) begin
          w_accept    = 1'b1;
          stall       = 1'b1;
          w_cnt_nxt   = CNT_W'(LATENCY - 1);
          w_state_nxt = S_BUSY;
        end
      end
      S_BUSY: begin
        stall = 1'b1;
        if (r_cnt == '0) begin
          w_commit    = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      S_DONE: begin
        // Inputs still show the finished instruction; never re-accept here.
        data_valid  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and latency counter.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Latched request; a simultaneous read+write is executed as a write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idx   <= '0;
      r_wdata <= '0;
      r_op_wr <= 1'b0;
    end else if (w_accept) begin
      r_idx   <= w_idx;
      r_wdata <= wdata;
      r_op_wr <= MemWrite;
    end
  end

  // Load result and sticky conflict flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rdata    <= '0;
      r_busy_err <= 1'b0;
    end else begin
      if (w_commit && !r_op_wr) begin
        r_rdata <= r_mem[r_idx];
      end
      if (w_accept && MemRead && MemWrite) begin
        r_busy_err <= 1'b1;
      end
    end
  end

  // Storage array: not reset; a write aborted by reset must not land.
  always_ff @(posedge clk) begin
    if (rst && w_commit && r_op_wr) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign rdata    = r_rdata;
  assign busy_err = r_busy_err;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder at the far end of the EX/MEM interface.
- Consumes MemWrite/MemRead, the ALU-computed byte address and the rt store data that leave the EX/MEM register.
- Models a multi-cycle 16-bit word memory. Drives a stall to the hazard unit while an access is pending, then presents read data to the MEM/WB register with a one-cycle valid strobe.

Parameters:
- MEM_AW, 10, word-address width; the array holds 2^MEM_AW 16-bit words.
- LATENCY, 4, cycles spent in BUSY before an access commits; legal range 1..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-low.
- MemWrite  input  1  store request from EX/MEM.
- MemRead  input  1  load request from EX/MEM.
- addr  input  16  byte address from EX/MEM ALU data.
- wdata  input  16  store data, rt value from EX/MEM.
- stall  output  1  hold request to the pipeline/hazard unit.
- data_valid  output  1  one-cycle strobe marking access completion.
- rdata  output  16  load result.
- busy_err  output  1  sticky flag; set when MemRead and MemWrite are both high when a request is accepted.

Behaviour:
- Reset (rst low at an edge):
  - state=IDLE, cnt=0, rdata=0x0000, data_valid=0, busy_err=0.
  - Latched request is discarded; a pending write is NOT committed.
  - Memory array contents are not reset.
- Word index = addr[MEM_AW:1].
  - addr[0] is ignored.
  - addr bits above MEM_AW are ignored, so addresses wrap modulo 2^(MEM_AW+1) bytes.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: req = MemRead|MemWrite.
    - If req: latch word index, wdata and op (write if MemWrite, else read); cnt<=LATENCY-1; go BUSY.
    - If both MemRead and MemWrite are high: op=write, busy_err<=1.
  - BUSY: inputs are ignored.
    - If cnt!=0: cnt<=cnt-1.
    - If cnt==0: commit. A write stores the latched wdata to the array; a read loads array[idx] into rdata. Go DONE.
  - DONE: data_valid=1 for this cycle only; go IDLE unconditionally.
    - Inputs still carry the completed instruction in this cycle and must not be re-accepted.
- stall is combinational: stall = (state==IDLE & req) | (state==BUSY).
  - For a request first visible at cycle T, stall is high for cycles T..T+LATENCY and low in DONE (T+LATENCY+1).
  - data_valid is high exactly at T+LATENCY+1.
- rdata holds its value until the next read commits. Writes never change rdata.
- Read-after-write to the same word in back-to-back accesses returns the new data, because commits are ordered.
- Back-to-back requests: the next request is accepted in the IDLE cycle right after DONE. Steady-state throughput is one access per LATENCY+2 cycles.
- No request in IDLE: stall=0, data_valid=0, state holds.
- busy_err clears only on reset.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then inputs low for 5 cycles -> stall=0, data_valid=0, rdata=0x0000, busy_err=0 throughout.
- Write then read, LATENCY=4: MemWrite, addr=0x0010, wdata=0xBEEF at T -> stall high T..T+4, data_valid at T+5, rdata stays 0x0000. Then MemRead, addr=0x0010 at T+6 -> data_valid at T+11, rdata=0xBEEF, stall low at T+11.
- Address aliasing: write 0x1234 to addr=0x0011 -> a read of 0x0010 returns 0x1234. Write 0xAAAA to addr=0x0800 (MEM_AW=10) -> a read of 0x0000 returns 0xAAAA.
- Reset mid-op: MemWrite to 0x0020 with 0x5555 (word previously 0x0000), assert rst=0 at T+2 -> state IDLE, stall=0. A later read of 0x0020 returns 0x0000, with no data_valid from the aborted write.
- Conflicting request: MemRead=MemWrite=1, addr=0x0004, wdata=0x0F0F -> treated as write, busy_err=1 and sticky. A read of 0x0004 returns 0x0F0F.
- DONE non-reaccept: hold MemRead high, addr constant, through DONE -> exactly one data_valid per LATENCY+2 cycles, never two consecutive data_valid cycles.
